serial_wide_sub: RTL and testbench
==================================

# serial_wide_sub

Multi-cycle wide-operand subtractor that computes `A - B - bin` for WIDTH-bit operands, one 4-bit nibble per clock. It sits directly upstream of the 4-bit full-subtractor datapath. Each cycle it feeds that datapath one operand nibble plus the registered borrow. It then collects the nibble difference and borrow-out and chains the borrow into the next cycle. It serves consumers that need wide subtraction without a full-width borrow chain.

## Interface
Parameters:
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4. N = WIDTH/4 nibbles.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request a subtraction. Sampled only when `ready`=1.
- `a`  in  WIDTH: minuend. Captured on accepted `start`.
- `b`  in  WIDTH: subtrahend. Captured on accepted `start`.
- `bin`  in  1: borrow-in. Captured on accepted `start`.
- `ready`  out  1: high in IDLE. Start is accepted only when high.
- `done`  out  1: one-cycle pulse; result is valid.
- `diff`  out  WIDTH: result `a - b - bin` mod 2^WIDTH.
- `bout`  out  1: final borrow-out. 1 when `a < b + bin` (unsigned).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `ready`=1.
  - On `start`=1: latch `a`, `b`, `bin` into internal registers; idx=0; borrow register = `bin`; go to RUN.
  - On `start`=0: stay in IDLE.
- RUN, each cycle:
  - Compute nibble idx: `d = a[idx] ^ b[idx] ^ borrow`, `bo = (~a & b) | (~a & borrow) | (b & borrow)`, bitwise rippled inside the nibble.
  - Write d into `diff[4*idx+3:4*idx]`; borrow <= nibble borrow-out; idx++.
  - After nibble N-1: `bout` <= final borrow; go to DONE.
- DONE: `done`=1 for exactly this cycle; go to IDLE.
- `diff` and `bout` hold their values until the next accepted start. They are not cleared on accept; nibbles are overwritten progressively during RUN.
- `start` while `ready`=0 is ignored. No queuing.
- Operand inputs may change freely after the accepting edge.
- Reset values, all forced on any `rst`=1 edge including mid-RUN:
  - state = IDLE, `ready`=1, `done`=0, `diff`=0, `bout`=0, idx=0, borrow=0.
  - Any in-flight operation is discarded.
- Reset has priority over `start` on the same edge.

## Timing
- Let edge 0 be the edge that accepts `start`.
- RUN occupies edges 1..N.
- `done`=1 in the cycle after edge N, and `diff`/`bout` are final in that same cycle.
- `ready` returns high in the cycle after the `done` cycle.
- Latency, start to done: N cycles. Issue interval: N+2 cycles.
- For WIDTH=16: `done` is high 4 cycles after the start edge, and the next start can be accepted 6 cycles after it.
- No combinational path from inputs to outputs. All outputs are registered.

## Configuration
- Macro `SERIAL_WIDE_SUB_OVF_EN`.
- Defined:
  - Extra output `ovf`, 1 bit, registered.
  - Set in the DONE cycle to the signed two's-complement overflow `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, evaluated on the latched operands.
  - Holds until the next accepted start. Reset value 0.
- Not defined: port `ovf` and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `serial_wide_sub_pkg`:
  - FSM state enum (IDLE, RUN, DONE).
  - Constant `NIBBLE_W = 4`.
  - Function for the nibble-count `N` and the idx width `$clog2(N)`, minimum 1.
- One sub-module, `nibble_sub4`: a combinational 4-bit subtract of a nibble plus borrow-in, producing a 4-bit difference and borrow-out. It is instantiated once and time-multiplexed by idx.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> `done` after 4 cycles, `diff`=0x1000, `bout`=0.
- a=0x0000, b=0x0001, bin=0 -> `diff`=0xFFFF, `bout`=1. With the macro defined, `ovf`=0.
- a=0x0005, b=0x0005, bin=1 -> `diff`=0xFFFF, `bout`=1. This checks the borrow-in seed and the carry of the borrow across all nibbles.
- With `SERIAL_WIDE_SUB_OVF_EN`: a=0x8000, b=0x0001, bin=0 -> `diff`=0x7FFF, `bout`=0, `ovf`=1.
- Start a=0xFFFF, b=0x0001; assert `rst` for 1 cycle at RUN cycle 2 -> next cycle `ready`=1, `diff`=0, `bout`=0, and no `done` pulse. A following start with a=0x0010, b=0x0001 yields `diff`=0x000F.
- Pulse `start` every cycle with changing operands -> only starts sampled while `ready`=1 are accepted. `done` pulses exactly every 6 cycles, and each result matches the operands latched at its accepting edge.

Source files
------------

// File: rtl/serial_wide_sub_pkg.sv
// Shared types and sizing helpers for the nibble-serial wide subtractor.
// Combinational helpers only; no latency, no flow control.
package serial_wide_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int nibble_count(input int width);
        return width / NIBBLE_W;
    endfunction

    // A single-nibble operand still needs a 1-bit index register.
    function automatic int idx_width(input int width);
        int n;
        n = width / NIBBLE_W;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_sub4.sv
// 4-bit full subtractor (a - b - bin) with rippled borrow-out.
// Purely combinational; no flow control.
module nibble_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [4:0] br;

    assign br[0] = bin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign d[i]    = a[i] ^ b[i] ^ br[i];
        assign br[i+1] = (~a[i] & b[i]) | (~a[i] & br[i]) | (b[i] & br[i]);
    end

    assign bout = br[4];

endmodule

// File: rtl/serial_wide_sub.sv
// Wide a - b - bin computed one nibble per cycle; done pulses N cycles after the start edge.
// start is taken only while ready=1; issue interval N+2; SERIAL_WIDE_SUB_OVF_EN adds the ovf output.
module serial_wide_sub
    import serial_wide_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_WIDE_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = nibble_count(WIDTH);
    localparam int IW = idx_width(WIDTH);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic             borrow_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
    logic             nib_bo;
    logic             last;

    assign last  = (idx_q == IW'(N - 1));
    assign nib_a = a_q[{idx_q, 2'b00} +: NIBBLE_W];
    assign nib_b = b_q[{idx_q, 2'b00} +: NIBBLE_W];

    nibble_sub4 u_nib (
        .a    (nib_a),
        .b    (nib_b),
        .bin  (borrow_q),
        .d    (nib_d),
        .bout (nib_bo)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last)  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef SERIAL_WIDE_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready   <= (state_d == ST_IDLE);
            done    <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= bin;
                        idx_q    <= '0;
                    end
                end
                ST_RUN: begin
                    diff[{idx_q, 2'b00} +: NIBBLE_W] <= nib_d;
                    borrow_q <= nib_bo;
                    idx_q    <= idx_q + IW'(1);
                    if (last) begin
                        bout  <= nib_bo;
                        idx_q <= '0;
`ifdef SERIAL_WIDE_SUB_OVF_EN
                        // MSB nibble is being written this edge, so use its live value.
                        ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (nib_d[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_wide_sub.sv
// Directed bench for serial_wide_sub at WIDTH=16.
module tb_serial_wide_sub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        bin = 1'b0;
    logic        ready;
    logic        done;
    logic [15:0] diff;
    logic        bout;
`ifdef SERIAL_WIDE_SUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_wide_sub #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_WIDE_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] op_a(input int k);
        logic [15:0] r;
        r = 16'h1000 + 16'(k) * 16'h0123;
        return r;
    endfunction

    function automatic logic [15:0] op_b(input int k);
        logic [15:0] r;
        r = 16'h0F00 + 16'(k) * 16'h0311;
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff got %h want 0000", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b want 0", bout); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one start from IDLE, checks latency, result and ready return.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin,
                          input logic [15:0] ed, input logic eb, input string name);
        int cyc;
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = ~ta; b = ~tb_v; bin = ~tbin;
        cyc = 0;
        while (done !== 1'b1 && cyc < 12) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++; if (cyc != 4) begin errors++; $display("FAIL %s_latency got %0d want 4", name, cyc); end
        checks++; if (diff !== ed) begin errors++; $display("FAIL %s_diff got %h want %h", name, diff, ed); end
        checks++; if (bout !== eb) begin errors++; $display("FAIL %s_bout got %b want %b", name, bout, eb); end
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL %s_ready_after got ready=%b done=%b want ready=1 done=0", name, ready, done);
        end
    endtask

    task automatic test_basic();
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, "basic");
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, "underflow");
`ifdef SERIAL_WIDE_SUB_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL underflow_ovf got %b want 0", ovf); end
`endif
        run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, "bin_seed");
    endtask

`ifdef SERIAL_WIDE_SUB_OVF_EN
    task automatic test_ovf();
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, "ovf_case");
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf); end
    endtask
`endif

    task automatic test_mid_reset();
        int seen;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);           // accept edge
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);           // RUN edge 1
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);           // reset lands on RUN edge 2
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", ready); end
        checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL midrst_diff got %h want 0000", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout got %b want 0", bout); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", seen); end
        run_op(16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        logic [16:0] full;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            a = op_a(k); b = op_b(k); bin = k[0]; start = 1'b1;
            checks++; if (ready !== (k % 6 == 0)) begin
                errors++; $display("FAIL b2b_ready k=%0d got %b want %b", k, ready, (k % 6 == 0));
            end
            @(posedge clk);
            #1;
            checks++; if (done !== (k % 6 == 4)) begin
                errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, (k % 6 == 4));
            end
            if (k % 6 == 4) begin
                full = {1'b0, op_a(k - 4)} - {1'b0, op_b(k - 4)} - 17'((k - 4) % 2);
                checks++; if (diff !== full[15:0] || bout !== full[16]) begin
                    errors++; $display("FAIL b2b_result k=%0d got %h/%b want %h/%b", k, diff, bout, full[15:0], full[16]);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SERIAL_WIDE_SUB_OVF_EN
        test_ovf();
`endif
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
